skeleton_ram_capture: RTL and testbench
=======================================

// Module: skeleton_ram_capture
// PURPOSE
//   Host-side reader for the RAM/LUT test skeleton. Drives EN and the calc trigger,
//   advances the skeleton LUT one step per trigger, and stores each DATA_OUT word in a local buffer.
//   Stops on the skeleton RDY (LUT end) or when the buffer is full.
//   After that it serves the captured words and the latched skeleton header to the measurement host.
//   Sits between one skeleton instance and the device-side register/streaming interface.
// PARAMETERS
//   BITWIDTH_SYS   16  width of skeleton data bus and of RD_DATA
//   BITWIDTH_HEAD  32  header width; the skeleton header bus is BITWIDTH_HEAD-6 bits (26)
//   DEPTH_LOG2     8   capture buffer depth = 2**DEPTH_LOG2 words
//   SKEL_LATENCY   1   cycles from SKEL_TRGG high to SKEL_DATA_IN valid (range 1..15)
//   HEAD_TYPE      3   expected value of header bits [25:22] (skeleton type RAM)
// PORTS
//   CLK_SYS       in   1             system clock
//   RST           in   1             asynchronous reset, active-high
//   START         in   1             1-cycle pulse; begins a capture run
//   SKEL_EN       out  1             enable to skeleton
//   SKEL_TRGG     out  1             1-cycle step trigger to skeleton
//   SKEL_DATA_IN  in   BITWIDTH_SYS  skeleton DATA_OUT
//   SKEL_HEAD_IN  in   BITWIDTH_HEAD-6  skeleton DATA_HEAD
//   SKEL_RDY      in   1             skeleton LUT end flag
//   RD_REQ        in   1             1-cycle read request, host side
//   RD_DATA       out  BITWIDTH_SYS  read word
//   RD_VALID      out  1             RD_DATA valid, 1 cycle
//   HEAD_OUT      out  BITWIDTH_HEAD-6  header latched at START
//   COUNT         out  DEPTH_LOG2+1  number of words captured
//   BUSY          out  1             capture in progress
//   DONE          out  1             capture finished; buffer readable
//   OVERFLOW      out  1             run ended because the buffer filled before SKEL_RDY
//   ERR_HEAD      out  1             header type mismatch; run refused
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; wr_ptr=rd_ptr=0. Buffer contents are undefined.
//   FSM states:
//   - IDLE: on START, latch HEAD_OUT<=SKEL_HEAD_IN and clear COUNT/rd_ptr/OVERFLOW/ERR_HEAD/DONE.
//     If SKEL_HEAD_IN[25:22]!=HEAD_TYPE: set ERR_HEAD and DONE; go to IDLE.
//     Otherwise go to ARM.
//   - ARM: SKEL_EN<=1 (held through the run); go to STEP next cycle.
//   - STEP: SKEL_TRGG=1 for exactly this cycle; load lat_cnt=SKEL_LATENCY; go to WAIT.
//   - WAIT: decrement lat_cnt; at 0 go to SAMPLE.
//   - SAMPLE: write SKEL_DATA_IN to buf[wr_ptr]; COUNT++.
//     If SKEL_RDY: go to FIN.
//     Otherwise, if COUNT==2**DEPTH_LOG2 after the increment: set OVERFLOW and go to FIN.
//     Otherwise go to STEP.
//   - FIN: SKEL_EN<=0, DONE<=1, BUSY<=0; go to IDLE.
//   BUSY=1 in ARM..SAMPLE.
//   Step period is SKEL_LATENCY+2 cycles per word.
//   START while BUSY is ignored. START in IDLE with DONE=1 starts a fresh run and clears DONE.
//   Readout (any state; data meaningful only when DONE=1):
//   - RD_REQ -> RD_DATA=buf[rd_ptr] and RD_VALID=1 one cycle later; rd_ptr++.
//   - If rd_ptr>=COUNT: RD_DATA=0, RD_VALID=1, rd_ptr does not move.
//   - RD_REQ while BUSY: RD_VALID=1, RD_DATA=0, no pointer move.
//   - Back-to-back RD_REQ every cycle is supported at full rate.
//   Simultaneous events:
//   - SKEL_RDY and buffer-full in the same SAMPLE: the word is stored, OVERFLOW=0 (RDY wins).
//   - START and RD_REQ in the same cycle: the read uses the old rd_ptr, then rd_ptr clears.
//   RST mid-run: asynchronous return to IDLE with SKEL_EN=SKEL_TRGG=0 immediately; captured data is lost.
//   COUNT saturates at 2**DEPTH_LOG2 and never wraps. wr_ptr is not reused within a run.
// STRUCTURE
//   Shared include skeleton_defs.vh:
//   - FSM state encodings (IDLE, ARM, STEP, WAIT, SAMPLE, FIN)
//   - header field offsets: TYPE[25:22], ADR_A[21:16], ADR_B[15:10], BW_A[9:5], BW_B[4:0]
//   - HEAD_TYPE_RAM=4'd3
//   One sub-module: capture_buffer_ram, a simple dual-port synchronous RAM.
//   - Write port: write enable, address, data.
//   - Read port: registered, 1-cycle latency.
//   - Parameterised by BITWIDTH_SYS and DEPTH_LOG2.
//   FSM, pointers and flags live in the top module.
// TESTING
//   T1: skeleton model with RDY on the 5th word (0x1111..0x5555), SKEL_LATENCY=1
//       -> 5 SKEL_TRGG pulses spaced 3 cycles apart; COUNT=5; DONE=1; OVERFLOW=0;
//          5 RD_REQ return 0x1111..0x5555 in order; 6th RD_REQ returns 0.
//   T2: DEPTH_LOG2=3, model never asserts RDY
//       -> stop after 8 words; OVERFLOW=1; COUNT=8; SKEL_EN falls in FIN.
//   T3: SKEL_HEAD_IN with type=4'd5
//       -> ERR_HEAD=1 and DONE=1 one cycle after START; SKEL_TRGG never pulses; COUNT=0.
//   T4: assert RST during the 3rd WAIT
//       -> SKEL_EN/SKEL_TRGG/BUSY drop asynchronously; a new START then captures from word 0.
//   T5: extra START pulses while BUSY, plus RD_REQ while BUSY
//       -> run unaffected; reads give RD_VALID=1 with RD_DATA=0.
//   T6: SKEL_LATENCY=4, header 0x0C5_4210 (type 3)
//       -> HEAD_OUT=0x0C5_4210; the sample taken 4 cycles after each trigger matches the model.

Source files
------------

// File: rtl/skeleton_ram_capture_pkg.sv
// Shared types and constants for the RAM/LUT skeleton capture block.
package skeleton_ram_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStep,
    StWait,
    StSample,
    StFin
  } state_e;

  // Skeleton header layout, MSB first: TYPE[25:22] ADR_A[21:16] ADR_B[15:10] BW_A[9:5] BW_B[4:0].
  typedef struct packed {
    logic [3:0] head_type;
    logic [5:0] adr_a;
    logic [5:0] adr_b;
    logic [4:0] bw_a;
    logic [4:0] bw_b;
  } head_t;

  localparam logic [3:0] HeadTypeRam = 4'd3;

  function automatic logic [3:0] head_type_of(input head_t head);
    return head.head_type;
  endfunction

endpackage

// File: rtl/skeleton_ram_capture_if.sv
// Link between the capture block (master) and one RAM/LUT skeleton instance (slave).
interface skeleton_ram_capture_if #(
  parameter int unsigned BitwidthSys  = 16,
  parameter int unsigned BitwidthHead = 32
);

  logic                    skel_en;
  logic                    skel_trgg;
  logic [BitwidthSys-1:0]  skel_data_in;
  logic [BitwidthHead-7:0] skel_head_in;
  logic                    skel_rdy;

  modport master (
    output skel_en,
    output skel_trgg,
    input  skel_data_in,
    input  skel_head_in,
    input  skel_rdy
  );

  modport slave (
    input  skel_en,
    input  skel_trgg,
    output skel_data_in,
    output skel_head_in,
    output skel_rdy
  );

endinterface

// File: rtl/skeleton_ram_capture_buffer_ram.sv
// Simple dual-port capture RAM: synchronous write, registered read with 1-cycle latency.
module skeleton_ram_capture_buffer_ram #(
  parameter int unsigned BitwidthSys = 16,
  parameter int unsigned DepthLog2   = 8
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [DepthLog2-1:0]   waddr_i,
  input  logic [BitwidthSys-1:0] wdata_i,
  input  logic                   re_i,
  input  logic [DepthLog2-1:0]   raddr_i,
  output logic [BitwidthSys-1:0] rdata_o
);

  logic [BitwidthSys-1:0] mem_q [2**DepthLog2];
  logic [BitwidthSys-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/skeleton_ram_capture.sv
// Host-side reader for the RAM/LUT skeleton: steps the LUT, captures each word into a local
// buffer, then serves the captured words and the latched header to the host.
module skeleton_ram_capture
  import skeleton_ram_capture_pkg::*;
#(
  parameter int unsigned BitwidthSys  = 16,
  parameter int unsigned BitwidthHead = 32,
  parameter int unsigned DepthLog2    = 8,
  parameter int unsigned SkelLatency  = 1,
  parameter logic [3:0]  HeadType     = HeadTypeRam
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  skeleton_ram_capture_if.master  skel,
  input  logic                    start,
  input  logic                    rd_req,
  output logic [BitwidthSys-1:0]  rd_data,
  output logic                    rd_valid,
  output logic [BitwidthHead-7:0] head_out,
  output logic [DepthLog2:0]      count,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    err_head
);

  localparam logic [DepthLog2:0] CountFull = {1'b1, {DepthLog2{1'b0}}};
  localparam logic [DepthLog2:0] CountOne  = (DepthLog2+1)'(1);
  localparam logic [3:0]         LatLoad   = 4'(SkelLatency);

  state_e                  state_q, state_d;
  logic [3:0]              lat_cnt_q, lat_cnt_d;
  logic [DepthLog2:0]      count_q, count_d;
  logic [DepthLog2:0]      rd_ptr_q, rd_ptr_d;
  logic [BitwidthHead-7:0] head_q, head_d;
  logic                    skel_en_q, skel_en_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic                    err_head_q, err_head_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_zero_q, rd_zero_d;
  logic                    ram_we;
  logic [BitwidthSys-1:0]  ram_rdata;

  assign busy = state_q inside {StArm, StStep, StWait, StSample};

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    head_d     = head_q;
    skel_en_d  = skel_en_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    err_head_d = err_head_q;
    rd_valid_d = 1'b0;
    rd_zero_d  = 1'b0;
    ram_we     = 1'b0;

    // Reads past the captured words, or during a run, return a valid zero word.
    if (rd_req) begin
      rd_valid_d = 1'b1;
      if (busy || (rd_ptr_q >= count_q)) begin
        rd_zero_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + CountOne;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          head_d     = skel.skel_head_in;
          count_d    = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
          err_head_d = 1'b0;
          done_d     = 1'b0;
          if (head_type_of(head_t'(skel.skel_head_in)) != HeadType) begin
            err_head_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = StArm;
          end
        end
      end
      StArm: begin
        skel_en_d = 1'b1;
        state_d   = StStep;
      end
      StStep: begin
        lat_cnt_d = LatLoad;
        state_d   = StWait;
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q <= 4'd1) begin
          state_d = StSample;
        end
      end
      StSample: begin
        ram_we = 1'b1;
        if (count_q != CountFull) begin
          count_d = count_q + CountOne;
        end
        // RDY takes priority over a simultaneous buffer-full.
        if (skel.skel_rdy) begin
          state_d = StFin;
        end else if (count_d == CountFull) begin
          overflow_d = 1'b1;
          state_d    = StFin;
        end else begin
          state_d = StStep;
        end
      end
      StFin: begin
        skel_en_d = 1'b0;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lat_cnt_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      head_q     <= '0;
      skel_en_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_head_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      head_q     <= head_d;
      skel_en_q  <= skel_en_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      err_head_q <= err_head_d;
      rd_valid_q <= rd_valid_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  skeleton_ram_capture_buffer_ram #(
    .BitwidthSys(BitwidthSys),
    .DepthLog2  (DepthLog2)
  ) u_buffer (
    .clk_i  (clk_sys),
    .we_i   (ram_we),
    .waddr_i(count_q[DepthLog2-1:0]),
    .wdata_i(skel.skel_data_in),
    .re_i   (rd_req),
    .raddr_i(rd_ptr_q[DepthLog2-1:0]),
    .rdata_o(ram_rdata)
  );

  assign skel.skel_en   = skel_en_q;
  assign skel.skel_trgg = (state_q == StStep);
  assign rd_data        = (rd_valid_q && !rd_zero_q) ? ram_rdata : '0;
  assign rd_valid       = rd_valid_q;
  assign head_out       = head_q;
  assign count          = count_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign err_head       = err_head_q;

endmodule

// File: tb/tb_skeleton_ram_capture.sv
// Bench for skeleton_ram_capture: two instances (depth 8 / latency 1, depth 16 / latency 4)
// driven by behavioural skeleton models, read results checked against a scoreboard queue.
module tb_skeleton_ram_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: depth 8, latency 1
  skeleton_ram_capture_if #(.BitwidthSys(16), .BitwidthHead(32)) ifa ();
  logic        start_a = 1'b0, rd_req_a = 1'b0;
  logic [15:0] rd_data_a;
  logic        rd_valid_a, busy_a, done_a, ovf_a, err_a;
  logic [25:0] head_a;
  logic [3:0]  count_a;

  skeleton_ram_capture #(
    .BitwidthSys(16), .BitwidthHead(32), .DepthLog2(3), .SkelLatency(1), .HeadType(4'd3)
  ) u_dut_a (
    .clk_sys(clk), .rst(rst), .skel(ifa), .start(start_a), .rd_req(rd_req_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .head_out(head_a), .count(count_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .err_head(err_a)
  );

  // Instance B: depth 16, latency 4
  skeleton_ram_capture_if #(.BitwidthSys(16), .BitwidthHead(32)) ifb ();
  logic        start_b = 1'b0, rd_req_b = 1'b0;
  logic [15:0] rd_data_b;
  logic        rd_valid_b, busy_b, done_b, ovf_b, err_b;
  logic [25:0] head_b;
  logic [4:0]  count_b;

  skeleton_ram_capture #(
    .BitwidthSys(16), .BitwidthHead(32), .DepthLog2(4), .SkelLatency(4), .HeadType(4'd3)
  ) u_dut_b (
    .clk_sys(clk), .rst(rst), .skel(ifb), .start(start_b), .rd_req(rd_req_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .head_out(head_b), .count(count_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .err_head(err_b)
  );

  // Skeleton models: word n of a run is mul*(n+1)+add; LUT restarts while EN is low.
  int unsigned na = 0, nb = 0, rdy_at_a = 0, rdy_at_b = 0, lat_b = 0;
  logic [15:0] mul_a = '0, add_a = '0, mul_b = '0, add_b = '0;
  logic [15:0] exp_a[$], exp_b[$];
  int unsigned trg_a[$], trg_b[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      na <= 0; ifa.skel_data_in <= '0; ifa.skel_rdy <= 1'b0;
    end else if (!ifa.skel_en) begin
      na <= 0;
    end else if (ifa.skel_trgg) begin
      ifa.skel_data_in <= 16'(mul_a * (na + 1) + add_a);
      ifa.skel_rdy     <= (na + 1 == rdy_at_a);
      na               <= na + 1;
    end
  end

  // Model B shows junk until exactly 4 cycles after the trigger.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nb <= 0; lat_b <= 0; ifb.skel_data_in <= '0; ifb.skel_rdy <= 1'b0;
    end else if (!ifb.skel_en) begin
      nb <= 0; lat_b <= 0;
    end else if (ifb.skel_trgg) begin
      ifb.skel_data_in <= 16'hDEAD; ifb.skel_rdy <= 1'b0; lat_b <= 3;
    end else if (lat_b != 0) begin
      lat_b <= lat_b - 1;
      if (lat_b == 1) begin
        ifb.skel_data_in <= 16'(mul_b * (nb + 1) + add_b);
        ifb.skel_rdy     <= (nb + 1 == rdy_at_b);
        nb               <= nb + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (ifa.skel_trgg) trg_a.push_back(cyc);
    if (ifb.skel_trgg) trg_b.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run_a(input logic [25:0] head);
    @(negedge clk);
    ifa.skel_head_in = head; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic start_run_b(input logic [25:0] head);
    @(negedge clk);
    ifb.skel_head_in = head; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_a) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    ifa.skel_head_in = '0; ifb.skel_head_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, ovf_a, err_a, rd_valid_a, ifa.skel_en, ifa.skel_trgg} !== 7'd0) begin
      n_bad++; $display("FAIL reset_flags_a: got %b want 0", {busy_a, done_a, ovf_a, err_a,
                        rd_valid_a, ifa.skel_en, ifa.skel_trgg});
    end
    n_cmp++;
    if (count_a !== 4'd0 || head_a !== 26'd0 || rd_data_a !== 16'd0) begin
      n_bad++; $display("FAIL reset_values_a: count=%0d head=%h data=%h want 0", count_a, head_a,
                        rd_data_a);
    end
    n_cmp++;
    if ({busy_b, done_b, ifb.skel_en, ifb.skel_trgg} !== 4'd0 || count_b !== 5'd0) begin
      n_bad++; $display("FAIL reset_b: flags=%b count=%0d want 0", {busy_b, done_b, ifb.skel_en,
                        ifb.skel_trgg}, count_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_rdy_end();
    int unsigned base;
    bit ok;
    logic [15:0] e;
    mul_a = 16'h1111; add_a = 16'h0000; rdy_at_a = 5;
    for (int i = 1; i <= 5; i++) exp_a.push_back(16'(16'h1111 * i));
    exp_a.push_back(16'h0000);
    base = trg_a.size();
    start_run_a({4'd3, 22'h00ABC});
    wait_done_a(100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL t1_done: got timeout want done=1"); end
    n_cmp++;
    if (count_a !== 4'd5 || ovf_a !== 1'b0 || err_a !== 1'b0) begin
      n_bad++; $display("FAIL t1_status: count=%0d ovf=%b err=%b want 5/0/0", count_a, ovf_a,
                        err_a);
    end
    n_cmp++;
    if (trg_a.size() - base != 5) begin
      n_bad++; $display("FAIL t1_trig_count: got %0d want 5", trg_a.size() - base);
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (trg_a[base+i] - trg_a[base+i-1] != 3) begin
        n_bad++; $display("FAIL t1_trig_gap%0d: got %0d want 3", i,
                          trg_a[base+i] - trg_a[base+i-1]);
      end
    end
    rd_req_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) rd_req_a = 1'b0;
      e = exp_a.pop_front();
      n_cmp++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== e) begin
        n_bad++; $display("FAIL t1_read%0d: got valid=%b data=%h want valid=1 data=%h", i,
                          rd_valid_a, rd_data_a, e);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [15:0] e;
    mul_a = 16'd3; add_a = 16'hA000; rdy_at_a = 0;
    for (int i = 1; i <= 8; i++) exp_a.push_back(16'(16'hA000 + 3 * i));
    exp_a.push_back(16'h0000);
    start_run_a({4'd3, 22'h01234});
    wait_done_a(100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL t2_done: got timeout want done=1"); end
    n_cmp++;
    if (count_a !== 4'd8 || ovf_a !== 1'b1 || ifa.skel_en !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL t2_status: count=%0d ovf=%b en=%b busy=%b want 8/1/0/0", count_a,
                        ovf_a, ifa.skel_en, busy_a);
    end
    rd_req_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8) rd_req_a = 1'b0;
      e = exp_a.pop_front();
      n_cmp++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== e) begin
        n_bad++; $display("FAIL t2_read%0d: got valid=%b data=%h want valid=1 data=%h", i,
                          rd_valid_a, rd_data_a, e);
      end
    end
  endtask

  task automatic test_head_err();
    int unsigned base;
    base = trg_a.size();
    start_run_a({4'd5, 22'h12345});
    n_cmp++;
    if (err_a !== 1'b1 || done_a !== 1'b1 || count_a !== 4'd0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL t3_status: err=%b done=%b count=%0d busy=%b want 1/1/0/0", err_a,
                        done_a, count_a, busy_a);
    end
    n_cmp++;
    if (head_a !== {4'd5, 22'h12345}) begin
      n_bad++; $display("FAIL t3_head: got %h want %h", head_a, {4'd5, 22'h12345});
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (trg_a.size() != base || ifa.skel_en !== 1'b0) begin
      n_bad++; $display("FAIL t3_no_trig: pulses=%0d en=%b want 0/0", trg_a.size() - base,
                        ifa.skel_en);
    end
    rd_req_a = 1'b1;
    @(negedge clk);
    rd_req_a = 1'b0;
    n_cmp++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0000) begin
      n_bad++; $display("FAIL t3_read: got valid=%b data=%h want valid=1 data=0000", rd_valid_a,
                        rd_data_a);
    end
  endtask

  task automatic test_reset_midrun();
    int unsigned seen;
    bit ok;
    logic [15:0] e;
    mul_a = 16'h0101; add_a = 16'h0020; rdy_at_a = 4;
    start_run_a({4'd3, 22'h00001});
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      if (ifa.skel_trgg) seen++;
      if (seen < 3) @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (seen != 3 || ifa.skel_en !== 1'b1 || busy_a !== 1'b1) begin
      n_bad++; $display("FAIL t4_pre: trig=%0d en=%b busy=%b want 3/1/1", seen, ifa.skel_en,
                        busy_a);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (ifa.skel_en !== 1'b0 || ifa.skel_trgg !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL t4_async: en=%b trgg=%b busy=%b want 0/0/0", ifa.skel_en,
                        ifa.skel_trgg, busy_a);
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (count_a !== 4'd0 || done_a !== 1'b0) begin
      n_bad++; $display("FAIL t4_cleared: count=%0d done=%b want 0/0", count_a, done_a);
    end
    for (int i = 1; i <= 4; i++) exp_a.push_back(16'(16'h0020 + 16'h0101 * i));
    start_run_a({4'd3, 22'h00001});
    wait_done_a(100, ok);
    n_cmp++;
    if (!ok || count_a !== 4'd4 || ovf_a !== 1'b0) begin
      n_bad++; $display("FAIL t4_rerun: done=%b count=%0d ovf=%b want 1/4/0", ok, count_a,
                        ovf_a);
    end
    rd_req_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) rd_req_a = 1'b0;
      e = exp_a.pop_front();
      n_cmp++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== e) begin
        n_bad++; $display("FAIL t4_read%0d: got valid=%b data=%h want valid=1 data=%h", i,
                          rd_valid_a, rd_data_a, e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    logic [15:0] e;
    mul_a = 16'h0011; add_a = 16'h7000; rdy_at_a = 6;
    for (int i = 1; i <= 6; i++) exp_a.push_back(16'(16'h7000 + 16'h0011 * i));
    start_run_a({4'd3, 22'h2AAAA});
    for (int i = 0; i < 6; i++) begin
      ifa.skel_head_in = {4'd5, 22'h3FFFF};
      start_a = 1'b1; rd_req_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; rd_req_a = 1'b0;
      n_cmp++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 16'h0000) begin
        n_bad++; $display("FAIL t5_busy_read%0d: got valid=%b data=%h want valid=1 data=0000",
                          i, rd_valid_a, rd_data_a);
      end
      @(negedge clk);
    end
    wait_done_a(100, ok);
    n_cmp++;
    if (!ok || count_a !== 4'd6 || err_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_bad++; $display("FAIL t5_status: done=%b count=%0d err=%b ovf=%b want 1/6/0/0", ok,
                        count_a, err_a, ovf_a);
    end
    n_cmp++;
    if (head_a !== {4'd3, 22'h2AAAA}) begin
      n_bad++; $display("FAIL t5_head: got %h want %h", head_a, {4'd3, 22'h2AAAA});
    end
    rd_req_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) rd_req_a = 1'b0;
      e = exp_a.pop_front();
      n_cmp++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== e) begin
        n_bad++; $display("FAIL t5_read%0d: got valid=%b data=%h want valid=1 data=%h", i,
                          rd_valid_a, rd_data_a, e);
      end
    end
  endtask

  task automatic test_latency4();
    int unsigned base;
    bit ok;
    logic [15:0] e;
    mul_b = 16'h0123; add_b = 16'h0F00; rdy_at_b = 3;
    for (int i = 1; i <= 3; i++) exp_b.push_back(16'(16'h0F00 + 16'h0123 * i));
    base = trg_b.size();
    start_run_b(26'h0C54210);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_b) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok || count_b !== 5'd3 || ovf_b !== 1'b0 || err_b !== 1'b0) begin
      n_bad++; $display("FAIL t6_status: done=%b count=%0d ovf=%b err=%b want 1/3/0/0", ok,
                        count_b, ovf_b, err_b);
    end
    n_cmp++;
    if (head_b !== 26'h0C54210) begin
      n_bad++; $display("FAIL t6_head: got %h want 0c54210", head_b);
    end
    n_cmp++;
    if (trg_b.size() - base != 3) begin
      n_bad++; $display("FAIL t6_trig_count: got %0d want 3", trg_b.size() - base);
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (trg_b[base+i] - trg_b[base+i-1] != 6) begin
        n_bad++; $display("FAIL t6_trig_gap%0d: got %0d want 6", i,
                          trg_b[base+i] - trg_b[base+i-1]);
      end
    end
    rd_req_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) rd_req_b = 1'b0;
      e = exp_b.pop_front();
      n_cmp++;
      if (rd_valid_b !== 1'b1 || rd_data_b !== e) begin
        n_bad++; $display("FAIL t6_read%0d: got valid=%b data=%h want valid=1 data=%h", i,
                          rd_valid_b, rd_data_b, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rdy_end();
    test_overflow();
    test_head_err();
    test_reset_midrun();
    test_busy_ignore();
    test_latency4();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
